scan_test_ctrl: RTL and testbench

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_ctrl_if.sv | 41 ++++
 rtl/scan_test_ctrl.sv | 97 +++++++++
 tb/tb_scan_test_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_test_ctrl_if.sv
// scan_test_ctrl_if: control, serial-pattern and circuit-under-test bundle for scan_test_ctrl
// master: session driver (start/num_pat, serial bits, po_in); slave: the controller.
// SCAN_TEST_CTRL_GOLDEN_CMP_EN adds golden_sig (master->slave) and pass (slave->master).
interface scan_test_ctrl_if #(
  parameter int PI_W = 178,
  parameter int PO_W = 123,
  parameter int SIG_W = 32
);
  logic start;
  logic [15:0] num_pat;
  logic si_valid;
  logic si_data;
  logic si_ready;
  logic [PI_W-1:0] pi_out;
  logic [PO_W-1:0] po_in;
  logic busy;
  logic done;
  logic [15:0] pat_count;
  logic [SIG_W-1:0] signature;
`ifdef SCAN_TEST_CTRL_GOLDEN_CMP_EN
  logic [SIG_W-1:0] golden_sig;
  logic pass;
  modport master (
    output start, num_pat, si_valid, si_data, po_in, golden_sig,
    input si_ready, pi_out, busy, done, pat_count, signature, pass
  );
  modport slave (
    input start, num_pat, si_valid, si_data, po_in, golden_sig,
    output si_ready, pi_out, busy, done, pat_count, signature, pass
  );
`else
  modport master (
    output start, num_pat, si_valid, si_data, po_in,
    input si_ready, pi_out, busy, done, pat_count, signature
  );
  modport slave (
    input start, num_pat, si_valid, si_data, po_in,
    output si_ready, pi_out, busy, done, pat_count, signature
  );
`endif
endinterface

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: scan session sequencer -- shift a serial pattern in, apply it, wait, capture and compact the response
// Ports: clk; rst (asynchronous, active-high); bus (scan_test_ctrl_if.slave):
//   start/num_pat begin a session; si_valid/si_data/si_ready carry serial pattern bits;
//   pi_out drives the circuit under test, po_in is its response;
//   busy/done/pat_count/signature report session status.
// Optional: define SCAN_TEST_CTRL_GOLDEN_CMP_EN to add golden_sig input and pass output.
module scan_test_ctrl #(
  parameter int PI_W = 178,
  parameter int PO_W = 123,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(32'h04C11DB7),
  parameter logic [SIG_W-1:0] SEED = '0,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst,
  scan_test_ctrl_if.slave bus
);
  localparam int CW = $clog2(PI_W);
  localparam int SW = PI_W - 1;
  localparam int NSL = (PO_W + SIG_W - 1) / SIG_W;
  localparam int PW = NSL * SIG_W;
  typedef enum logic [2:0] {IDLE, SHIFT, APPLY, CAPTURE, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] bit_cnt;
  logic [3:0] settle_cnt;
  logic [SW-1:0] shreg;
  logic [PI_W-1:0] pi_q;
  logic [15:0] num_lat, pat_cnt;
  logic [SIG_W-1:0] sig, fold, sig_next;
  logic [PW-1:0] po_pad;
  logic last_bit, settled;
  assign last_bit = bit_cnt == CW'(PI_W - 1);
  assign settled = settle_cnt == 4'(SETTLE - 1);
  // The final bit goes straight into pi_out, so the shift register holds only the first PI_W-1 bits.
  always_comb begin
    po_pad = PW'(bus.po_in);
    fold = '0;
    for (int i = 0; i < NSL; i++) fold ^= po_pad[i*SIG_W +: SIG_W];
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (bus.start) state_d = bus.num_pat == '0 ? DONE : SHIFT;
      SHIFT: if (bus.si_valid && last_bit) state_d = APPLY;
      APPLY: if (settled) state_d = CAPTURE;
      CAPTURE: state_d = pat_cnt + 16'd1 == num_lat ? DONE : SHIFT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      settle_cnt <= '0;
      shreg <= '0;
      pi_q <= '0;
      num_lat <= '0;
      pat_cnt <= '0;
      sig <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          num_lat <= bus.num_pat;
          sig <= SEED;
          pat_cnt <= '0;
          bit_cnt <= '0;
          settle_cnt <= '0;
        end
        SHIFT: if (bus.si_valid) begin
          shreg <= SW'({shreg, bus.si_data});
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (last_bit) pi_q <= {shreg, bus.si_data};
        end
        APPLY: settle_cnt <= settled ? '0 : settle_cnt + 4'd1;
        CAPTURE: begin
          sig <= sig_next;
          pat_cnt <= pat_cnt + 16'd1;
          bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
  assign bus.si_ready = state == SHIFT;
  assign bus.busy = state == SHIFT || state == APPLY || state == CAPTURE;
  assign bus.done = state == DONE;
  assign bus.pi_out = pi_q;
  assign bus.pat_count = pat_cnt;
  assign bus.signature = sig;
`ifdef SCAN_TEST_CTRL_GOLDEN_CMP_EN
  assign bus.pass = state == DONE && sig == bus.golden_sig;
`endif
endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: randomized scan sessions checked cycle by cycle against a session-level reference model
module tb_scan_test_ctrl;
  localparam int PI_W = 8, PO_W = 4, SIG_W = 4, SETTLE = 2;
  localparam logic [SIG_W-1:0] POLY = 4'h9, SEED = 4'h0;
  logic clk = 0, rst = 1;
  int n_cmp = 0, n_err = 0;
  scan_test_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W), .SIG_W(SIG_W)) bus ();
  scan_test_ctrl #(
    .PI_W(PI_W), .PO_W(PO_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED), .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  bit m_busy = 0, m_done = 0;
  int m_wait = -1, m_cnt = 0, m_n = 0;
  logic [PI_W-1:0] m_pi = '0;
  logic [SIG_W-1:0] m_sig = '0;
  bit m_q[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [SIG_W-1:0] compact(input logic [SIG_W-1:0] s, input logic [PO_W-1:0] po);
    logic [SIG_W-1:0] r;
    r = s[SIG_W-1] ? (s << 1) ^ POLY : s << 1;
    for (int i = 0; i < PO_W; i++) r[i % SIG_W] ^= po[i];
    return r;
  endfunction
  // m_wait: -1 while collecting bits, SETTLE..1 while applying, 0 on the capture cycle
  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_done = 0; m_wait = -1; m_cnt = 0; m_pi = '0; m_sig = '0;
      m_q.delete();
    end else if (!m_busy) begin
      if (bus.start) begin
        m_sig = SEED; m_cnt = 0; m_n = int'(bus.num_pat);
        m_busy = bus.num_pat != 0; m_done = !m_busy; m_wait = -1;
        m_q.delete();
      end
    end else if (m_wait < 0) begin
      if (bus.si_valid) begin
        m_q.push_back(bus.si_data);
        if (m_q.size() == PI_W) begin
          for (int i = 0; i < PI_W; i++) m_pi[PI_W-1-i] = m_q[i];
          m_q.delete();
          m_wait = SETTLE;
        end
      end
    end else if (m_wait > 0) m_wait--;
    else begin
      m_sig = compact(m_sig, bus.po_in);
      m_cnt++;
      m_wait = -1;
      if (m_cnt == m_n) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
    #2;
    chk("si_ready", 32'(bus.si_ready), 32'(m_busy && m_wait < 0));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("pi_out", 32'(bus.pi_out), 32'(m_pi));
    chk("pat_count", 32'(bus.pat_count), 32'(m_cnt));
    chk("signature", 32'(bus.signature), 32'(m_sig));
`ifdef SCAN_TEST_CTRL_GOLDEN_CMP_EN
    chk("pass", 32'(bus.pass), 32'(m_done && m_sig == bus.golden_sig));
`endif
  end
  task automatic do_start(input int n);
    @(negedge clk);
    bus.start = 1;
    bus.num_pat = 16'(n);
    @(negedge clk);
    bus.start = 0;
    bus.num_pat = 16'($urandom);
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 64 && !bus.si_ready; i++) @(negedge clk);
    chk("ready_wait", 32'(bus.si_ready), 32'd1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200 && !bus.done; i++) @(negedge clk);
    chk("done_wait", 32'(bus.done), 32'd1);
  endtask
  // mode 0: valid every cycle; 1: valid toggles 1,0,1,0; 2: random valid plus stray start pulses
  task automatic send_bits(input logic [PI_W-1:0] p, input int nb, input int mode);
    int i = PI_W - 1;
    int t = 0;
    bit v, acc;
    while (i > PI_W - 1 - nb && t < 400) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? !t[0] : ($urandom_range(0, 2) != 0);
      acc = v && bus.si_ready;
      bus.si_valid = v;
      bus.si_data = v ? p[i] : 1'($urandom);
      bus.start = mode == 2 && bus.busy && $urandom_range(0, 7) == 0;
      bus.num_pat = 16'($urandom);
      @(negedge clk);
      if (acc) i--;
      t++;
    end
    bus.si_valid = 0;
    bus.start = 0;
    chk("shift_budget", 32'(i), 32'(PI_W - 1 - nb));
  endtask
  task automatic send_pat(input logic [PI_W-1:0] p, input logic [PO_W-1:0] po, input int mode);
    wait_ready();
    bus.po_in = po;
    send_bits(p, PI_W, mode);
  endtask
  initial begin
    bus.start = 0; bus.num_pat = 0; bus.si_valid = 0; bus.si_data = 0; bus.po_in = 0;
`ifdef SCAN_TEST_CTRL_GOLDEN_CMP_EN
    bus.golden_sig = 4'h8;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.si_ready), 32'd0);
    chk("rst_pi", 32'(bus.pi_out), 32'd0);
    rst = 0;
    do_start(1);
    send_pat(8'hB2, 4'h3, 0);
    chk("shift_pi", 32'(bus.pi_out), 32'hB2);
    chk("apply_ready", 32'(bus.si_ready), 32'd0);
    chk("apply_busy", 32'(bus.busy), 32'd1);
    wait_done();
    chk("one_cnt", 32'(bus.pat_count), 32'd1);
    do_start(2);
    send_pat(8'h5C, 4'hA, 0);
    wait_ready();
    chk("cap1_sig", 32'(bus.signature), 32'hA);
    send_pat(8'h3E, 4'h5, 0);
    wait_done();
    chk("final_sig", 32'(bus.signature), 32'h8);
    chk("final_cnt", 32'(bus.pat_count), 32'd2);
    chk("final_done", 32'(bus.done), 32'd1);
`ifdef SCAN_TEST_CTRL_GOLDEN_CMP_EN
    #1 chk("pass_hit", 32'(bus.pass), 32'd1);
    bus.golden_sig = 4'h7;
    #1 chk("pass_miss", 32'(bus.pass), 32'd0);
    bus.golden_sig = 4'h8;
`endif
    repeat (4) @(negedge clk);
    chk("hold_sig", 32'(bus.signature), 32'h8);
    do_start(1);
    send_pat(8'hC5, 4'h6, 1);
    chk("bp_pi", 32'(bus.pi_out), 32'hC5);
    chk("bp_ready", 32'(bus.si_ready), 32'd0);
    wait_done();
    do_start(0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    chk("zero_sig", 32'(bus.signature), 32'd0);
    chk("zero_cnt", 32'(bus.pat_count), 32'd0);
    do_start(1);
    @(negedge clk);
    bus.start = 1;
    bus.num_pat = 16'd5;
    @(negedge clk);
    bus.start = 0;
    send_pat(8'h71, 4'h9, 0);
    wait_done();
    chk("busy_start_cnt", 32'(bus.pat_count), 32'd1);
    do_start(1);
    wait_ready();
    send_bits(8'hFF, 5, 0);
    rst = 1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.si_ready), 32'd0);
    chk("mid_rst_pi", 32'(bus.pi_out), 32'd0);
    chk("mid_rst_sig", 32'(bus.signature), 32'd0);
    chk("mid_rst_cnt", 32'(bus.pat_count), 32'd0);
    @(negedge clk);
    rst = 0;
    do_start(1);
    send_pat(8'h96, 4'h2, 0);
    chk("post_rst_pi", 32'(bus.pi_out), 32'h96);
    wait_done();
    repeat (30) begin
      int n;
      n = $urandom_range(1, 3);
      do_start(n);
      for (int k = 0; k < n; k++) send_pat(PI_W'($urandom), PO_W'($urandom), 2);
      wait_done();
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
